// File: rtl/mem_stage.sv
// Memory stage: E/M pipeline register, 4 KB word-addressed data memory,
// byte/halfword store merging and load extraction with sign/zero extension.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_E,
  input  logic [31:0] ALU_E,
  input  logic [31:0] rt_E,
  input  logic [4:0]  RDst_E,
  input  logic [31:0] PC8_E,
  output logic [31:0] IR_M_out,
  output logic [31:0] ALU_M_out,
  output logic [31:0] PC8_M_out,
  output logic [4:0]  RDst_M_out,
  output logic [31:0] DM_out,
  output logic        Load_M,
  output logic        Save_M
);

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  rdst;
    logic [31:0] pc8;
  } em_t;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  em_t em_d, em_q;

  always_comb begin
    em_d = '{ir: IR_E, alu: ALU_E, rt: rt_E,
             rdst: RDst_E, pc8: PC8_E};
  end

  always_ff @(posedge clk) begin
    if (reset) em_q <= '0;
    else       em_q <= em_d;
  end

  logic [5:0]  op;
  logic        is_lw, is_lh, is_lhu, is_lb, is_lbu;
  logic        is_sw, is_sh, is_sb;

  always_comb begin
    op     = em_q.ir[31:26];
    is_lw  = 1'b0;
    is_lh  = 1'b0;
    is_lhu = 1'b0;
    is_lb  = 1'b0;
    is_lbu = 1'b0;
    is_sw  = 1'b0;
    is_sh  = 1'b0;
    is_sb  = 1'b0;
    unique case (op)
      OP_LW:   is_lw  = 1'b1;
      OP_LH:   is_lh  = 1'b1;
      OP_LHU:  is_lhu = 1'b1;
      OP_LB:   is_lb  = 1'b1;
      OP_LBU:  is_lbu = 1'b1;
      OP_SW:   is_sw  = 1'b1;
      OP_SH:   is_sh  = 1'b1;
      OP_SB:   is_sb  = 1'b1;
      default: ;
    endcase
  end

  logic [31:0] mem_q [1024];
  logic [9:0]  idx;
  logic [1:0]  lane;
  logic [31:0] rd_word;
  logic [31:0] wdata_d;
  logic        we_d;

  assign idx     = em_q.alu[11:2];
  assign lane    = em_q.alu[1:0];
  assign rd_word = mem_q[idx];

  // Partial stores merge into the word currently held at the index
  always_comb begin
    wdata_d = rd_word;
    we_d    = is_sw | is_sh | is_sb;
    unique case (1'b1)
      is_sw: wdata_d = em_q.rt;
      is_sh: begin
        if (lane[1]) wdata_d[31:16] = em_q.rt[15:0];
        else         wdata_d[15:0]  = em_q.rt[15:0];
      end
      is_sb: begin
        unique case (lane)
          2'd0: wdata_d[7:0]   = em_q.rt[7:0];
          2'd1: wdata_d[15:8]  = em_q.rt[7:0];
          2'd2: wdata_d[23:16] = em_q.rt[7:0];
          2'd3: wdata_d[31:24] = em_q.rt[7:0];
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem_q[i] <= '0;
    end else if (we_d) begin
      mem_q[idx] <= wdata_d;
    end
  end

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half     = lane[1] ? rd_word[31:16] : rd_word[15:0];
    byte_sel = rd_word[7:0];
    unique case (lane)
      2'd0: byte_sel = rd_word[7:0];
      2'd1: byte_sel = rd_word[15:8];
      2'd2: byte_sel = rd_word[23:16];
      2'd3: byte_sel = rd_word[31:24];
      default: ;
    endcase
    DM_out = rd_word;
    unique case (1'b1)
      is_lh:  DM_out = {{16{half[15]}}, half};
      is_lhu: DM_out = {16'h0, half};
      is_lb:  DM_out = {{24{byte_sel[7]}}, byte_sel};
      is_lbu: DM_out = {24'h0, byte_sel};
      default: ;
    endcase
  end

  assign IR_M_out   = em_q.ir;
  assign ALU_M_out  = em_q.alu;
  assign PC8_M_out  = em_q.pc8;
  assign RDst_M_out = em_q.rdst;
  assign Load_M     = is_lw | is_lh | is_lhu | is_lb | is_lbu;
  assign Save_M     = is_sw | is_sh | is_sb;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected
// M-stage results; a negedge monitor pops and compares them.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_E, ALU_E, rt_E, PC8_E;
  logic [4:0]  RDst_E;
  logic [31:0] IR_M_out, ALU_M_out, PC8_M_out, DM_out;
  logic [4:0]  RDst_M_out;
  logic        Load_M, Save_M;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .IR_E(IR_E), .ALU_E(ALU_E), .rt_E(rt_E),
    .RDst_E(RDst_E), .PC8_E(PC8_E),
    .IR_M_out(IR_M_out), .ALU_M_out(ALU_M_out),
    .PC8_M_out(PC8_M_out), .RDst_M_out(RDst_M_out),
    .DM_out(DM_out), .Load_M(Load_M), .Save_M(Save_M)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] ir, alu, pc8, dm;
    logic [4:0]  rdst;
    logic        ld, sv;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      exp_t e;
      e = q.pop_front();
      cmp("ir_m", IR_M_out, e.ir);
      cmp("alu_m", ALU_M_out, e.alu);
      cmp("pc8_m", PC8_M_out, e.pc8);
      cmp("rdst_m", {27'h0, RDst_M_out}, {27'h0, e.rdst});
      cmp("load_m", {31'h0, Load_M}, {31'h0, e.ld});
      cmp("save_m", {31'h0, Save_M}, {31'h0, e.sv});
      cmp("dm_out", DM_out, e.dm);
    end
  end

  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001,
    LHU = 6'b100101, LB = 6'b100000, LBU = 6'b100100,
    SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
  localparam logic [31:0] ADDU = 32'h0022_1821;

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 5'd4, 5'd3, 16'h0};
  endfunction

  // Issue one instruction into E; dm is the hand-computed DM_out in M
  task automatic issue(input logic rst, input logic [31:0] ir,
                       input logic [31:0] alu, input logic [31:0] rt,
                       input logic [31:0] dm);
    exp_t e;
    logic [5:0] op;
    @(negedge clk);
    n++;
    reset  = rst;
    IR_E   = ir;
    ALU_E  = alu;
    rt_E   = rt;
    RDst_E = 5'(n);
    PC8_E  = 32'h3000 + 32'(n) * 4;
    op     = ir[31:26];
    e.cyc  = cyc;
    e.dm   = dm;
    if (rst) begin
      e.ir = '0; e.alu = '0; e.pc8 = '0; e.rdst = '0;
      e.ld = 1'b0; e.sv = 1'b0;
    end else begin
      e.ir = ir; e.alu = alu; e.pc8 = PC8_E; e.rdst = RDst_E;
      e.ld = (op == LW) || (op == LH) || (op == LHU) ||
             (op == LB) || (op == LBU);
      e.sv = (op == SW) || (op == SH) || (op == SB);
    end
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    IR_E = '0; ALU_E = '0; rt_E = '0; RDst_E = '0; PC8_E = '0;
    issue(1, mk(SW), 32'h10, 32'h5555, 32'h0);
    issue(1, 32'h0, 32'h0, 32'h0, 32'h0);
    issue(0, mk(SW),  32'h10, 32'h12345678, 32'h0);
    issue(0, mk(LW),  32'h10, 32'h0, 32'h12345678);
    issue(0, mk(SB),  32'h13, 32'hAB, 32'h12345678);
    issue(0, mk(LB),  32'h13, 32'h0, 32'hFFFFFFAB);
    issue(0, mk(LBU), 32'h13, 32'h0, 32'h000000AB);
    issue(0, mk(LW),  32'h10, 32'h0, 32'hAB345678);
    issue(0, mk(SH),  32'h12, 32'h00008001, 32'hAB345678);
    issue(0, mk(LH),  32'h12, 32'h0, 32'hFFFF8001);
    issue(0, mk(LHU), 32'h12, 32'h0, 32'h00008001);
    issue(0, mk(LH),  32'h10, 32'h0, 32'h00005678);
    issue(0, mk(LW),  32'h10, 32'h0, 32'h80015678);
    issue(0, mk(SB),  32'h40, 32'h123456EF, 32'h0);
    issue(0, mk(SB),  32'h41, 32'h0000007F, 32'h000000EF);
    issue(0, mk(LB),  32'h40, 32'h0, 32'hFFFFFFEF);
    issue(0, mk(LB),  32'h41, 32'h0, 32'h0000007F);
    issue(0, mk(SW),  32'h1004, 32'hDEADBEEF, 32'h0);
    issue(0, mk(LW),  32'h0004, 32'h0, 32'hDEADBEEF);
    issue(0, mk(LW),  32'h1007, 32'h0, 32'hDEADBEEF);
    issue(0, mk(SW),  32'h30, 32'h11111111, 32'h0);
    issue(0, ADDU,    32'h30, 32'h22222222, 32'h11111111);
    issue(0, mk(LW),  32'h30, 32'h0, 32'h11111111);
    issue(0, mk(SW),  32'h20, 32'hCAFEF00D, 32'h0);
    issue(1, mk(LW),  32'h20, 32'h0, 32'h0);
    issue(0, mk(LW),  32'h20, 32'h0, 32'h0);
    issue(0, mk(LW),  32'h30, 32'h0, 32'h0);
    issue(0, mk(LW),  32'h0004, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    IR_E = '0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL be clocked by a single clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for the E/M register and data memory.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: IR_E  input  32  instruction leaving E.
REQ-005 Port: ALU_E  input  32  E result (ALU, PC+8 or HI/LO), used as memory address for loads and stores.
REQ-006 Port: rt_E  input  32  store data from E, already forwarded.
REQ-007 Port: RDst_E  input  5  destination register from E.
REQ-008 Port: PC8_E  input  32  PC+8 from E.
REQ-009 Port: IR_M_out, ALU_M_out, PC8_M_out  output  32 each  registered copies for W and forwarding.
REQ-010 Port: RDst_M_out  output  5  registered destination register.
REQ-011 Port: DM_out  output  32  load data after byte/half selection and extension.
REQ-012 Port: Load_M, Save_M  output  1 each  IR_M is a load / a store.

Function
REQ-013 SHALL hold an E/M register (IR, ALU, rt, RDst, PC8) that loads all E inputs on every rising clk; M never stalls.
REQ-014 SHALL contain a 1024 x 32 data memory indexed by ALU_M[11:2]; ALU_M[31:12] ignored, so addresses wrap every 4 KB.
REQ-015 Decode from IR_M[31:26]: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000; any other opcode is neither load nor store.
REQ-016 sw SHALL write all 4 bytes of rt_M at the rising edge ending the cycle in which sw is in M; ALU_M[1:0] ignored.
REQ-017 sh SHALL write rt_M[15:0] into halfword ALU_M[1] (1 = bits 31:16); ALU_M[0] ignored; other halfword unchanged.
REQ-018 sb SHALL write rt_M[7:0] into byte lane ALU_M[1:0] (0 = bits 7:0); other bytes unchanged.
REQ-019 DM_out SHALL be combinational from the current memory word and IR_M/ALU_M: lw whole word; lh/lhu selected halfword sign-/zero-extended; lb/lbu selected byte sign-/zero-extended; non-loads output the raw word.
REQ-020 A load in M in the cycle after a store to the same word SHALL read the updated data (write at edge, read after).
REQ-021 Non-store instructions SHALL never modify memory.
REQ-022 Load_M and Save_M SHALL be combinational decodes of IR_M per REQ-015.

Reset
REQ-023 A rising clk with reset=1 SHALL clear every E/M register field to 0 (IR_M=0 decodes as nop) and clear all 1024 memory words to 0.
REQ-024 If a store is in M during the reset cycle, the reset SHALL take priority and the store SHALL not write.
REQ-025 After reset, all outputs are 0 (DM_out = word 0 = 0) until new E inputs are captured.

Verification
REQ-026 Reset, then sw rt=0x12345678 to addr 0x10, next cycle lw 0x10 -> DM_out=0x12345678 while lw is in M.
REQ-027 After REQ-026: sb rt=0xAB to 0x13, then lb 0x13 -> 0xFFFFFFAB; lbu 0x13 -> 0x000000AB; lw 0x10 -> 0xAB345678.
REQ-028 sh rt=0x00008001 to 0x12, then lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001; lh 0x10 -> 0x00005678.
REQ-029 sw 0xDEADBEEF to 0x1004, then lw 0x0004 -> 0xDEADBEEF (4 KB wrap); lw 0x1007 -> 0xDEADBEEF (low bits ignored).
REQ-030 sw 0xCAFEF00D at 0x20 in M with reset=1 in that cycle -> after reset, lw 0x20 -> 0x00000000 and IR_M_out=0.
REQ-031 addu in M with ALU_E=0x30, following earlier sw 0x11111111 to 0x30 -> memory word 0x30 unchanged at 0x11111111; ALU_M_out=0x30, Load_M=Save_M=0.
